// File: rtl/ib_lut_load_scheduler.sv
// IB-LUT ROM read-port scheduler: grants one CN/VN/DN update request at a time,
// streams the current iteration's ROM page into the target RAM, then acknowledges.
module ib_lut_load_scheduler #(
    parameter int unsigned CN_FUN_NUM    = 2,
    parameter int unsigned VN_FUN_NUM    = 2,
    parameter int unsigned ITER_MAX      = 10,
    parameter int unsigned ADDR_W        = 5,
    parameter int unsigned CN_PAGE_WORDS = 32,
    parameter int unsigned VN_PAGE_WORDS = 16,
    localparam int unsigned ITER_W       = $clog2(ITER_MAX)
) (
    input  logic                     write_clk,
    input  logic                     rstn,
    input  logic [CN_FUN_NUM-1:0]    cnu_wr,
    input  logic [VN_FUN_NUM-1:0]    vnu_wr,
    input  logic                     dnu_wr,
    input  logic                     iter_termination,
    output logic                     rom_en,
    output logic [ITER_W+ADDR_W-1:0] rom_addr,
    output logic [CN_FUN_NUM-1:0]    cn_ram_we,
    output logic [VN_FUN_NUM-1:0]    vn_ram_we,
    output logic                     dn_ram_we,
    output logic [ADDR_W-1:0]        ram_waddr,
    output logic [CN_FUN_NUM-1:0]    cn_iter_update,
    output logic [VN_FUN_NUM-1:0]    vn_iter_update,
    output logic                     dn_iter_update,
    output logic [ITER_W-1:0]        iter_cnt,
    output logic                     max_iter,
    output logic                     busy,
    output logic [2:0]               state
);

    // Requester vector layout: [CN_FUN_NUM-1:0] CN, then VN, then DN in the MSB.
    localparam int unsigned REQ_W = CN_FUN_NUM + VN_FUN_NUM + 1;

    localparam logic [ADDR_W-1:0] CN_LAST   = ADDR_W'(CN_PAGE_WORDS - 1);
    localparam logic [ADDR_W-1:0] VN_LAST   = ADDR_W'(VN_PAGE_WORDS - 1);
    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(ITER_MAX - 1);

    typedef enum logic [2:0] {
        StIdle      = 3'b000,
        StRomFetch0 = 3'b001,
        StRamLoad   = 3'b010,
        StFinish    = 3'b100
    } state_e;

    state_e             state_q, state_d;
    logic [REQ_W-1:0]   grant_q, grant_d;
    logic [REQ_W-1:0]   mask_q, mask_d;
    logic [ADDR_W-1:0]  word_q, word_d;
    logic [ITER_W-1:0]  iter_q, iter_d;
    logic               max_iter_q, max_iter_d;

    logic [REQ_W-1:0]   req_vec;
    logic [REQ_W-1:0]   req_pick;
    logic               grant_is_cn;
    logic               grant_is_dn;
    logic               load_last;

    logic [ADDR_W-1:0]  rom_word;
    logic [REQ_W-1:0]   we_vec;
    logic [REQ_W-1:0]   ack_vec;

    // Fixed-priority pick over unmasked requests; lowest index (cnu_wr[0]) wins.
    always_comb begin
        req_vec  = {dnu_wr, vnu_wr, cnu_wr} & ~mask_q;
        req_pick = '0;
        for (int i = 0; i < REQ_W; i++) begin
            if (req_vec[i] && (req_pick == '0)) begin
                req_pick[i] = 1'b1;
            end
        end
    end

    // Page length depends on the target: CN pages are longer than VN/DN pages.
    always_comb begin
        grant_is_cn = |grant_q[CN_FUN_NUM-1:0];
        grant_is_dn = grant_q[REQ_W-1];
        load_last   = (word_q == (grant_is_cn ? CN_LAST : VN_LAST));
    end

    // Next-state logic; termination overrides everything and returns to idle.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        mask_d     = '0;
        word_d     = word_q;
        iter_d     = iter_q;
        max_iter_d = 1'b0;
        if (iter_termination) begin
            state_d = StIdle;
            grant_d = '0;
            word_d  = '0;
            iter_d  = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_pick != '0) begin
                        grant_d = req_pick;
                        word_d  = '0;
                        state_d = StRomFetch0;
                    end
                end
                StRomFetch0: begin
                    state_d = StRamLoad;
                end
                StRamLoad: begin
                    if (load_last) begin
                        state_d    = StFinish;
                        // Registered so the pulse lines up with the FINISH acknowledge.
                        max_iter_d = grant_is_dn && (iter_q == ITER_LAST);
                    end else begin
                        word_d = word_q + ADDR_W'(1);
                    end
                end
                StFinish: begin
                    state_d = StIdle;
                    // The acknowledged requester drops its request one cycle late.
                    mask_d  = grant_q;
                    grant_d = '0;
                    word_d  = '0;
                    if (grant_is_dn) begin
                        iter_d = (iter_q == ITER_LAST) ? '0 : iter_q + ITER_W'(1);
                    end
                end
                default: begin
                    state_d = StIdle;
                    grant_d = '0;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge write_clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= StIdle;
            grant_q    <= '0;
            mask_q     <= '0;
            word_q     <= '0;
            iter_q     <= '0;
            max_iter_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            mask_q     <= mask_d;
            word_q     <= word_d;
            iter_q     <= iter_d;
            max_iter_q <= max_iter_d;
        end
    end

    // Moore output decode: ROM runs one word ahead of the RAM write address.
    always_comb begin
        rom_en    = 1'b0;
        rom_word  = '0;
        we_vec    = '0;
        ack_vec   = '0;
        ram_waddr = '0;
        unique case (state_q)
            StRomFetch0: begin
                rom_en = 1'b1;
            end
            StRamLoad: begin
                we_vec    = grant_q;
                ram_waddr = word_q;
                if (!load_last) begin
                    rom_en   = 1'b1;
                    rom_word = word_q + ADDR_W'(1);
                end
            end
            StFinish: begin
                ack_vec = grant_q;
            end
            default: ;
        endcase
    end

    assign rom_addr       = {iter_q, rom_word};
    assign cn_ram_we      = we_vec[CN_FUN_NUM-1:0];
    assign vn_ram_we      = we_vec[CN_FUN_NUM +: VN_FUN_NUM];
    assign dn_ram_we      = we_vec[REQ_W-1];
    assign cn_iter_update = ack_vec[CN_FUN_NUM-1:0];
    assign vn_iter_update = ack_vec[CN_FUN_NUM +: VN_FUN_NUM];
    assign dn_iter_update = ack_vec[REQ_W-1];
    assign iter_cnt       = iter_q;
    assign max_iter       = max_iter_q;
    assign busy           = (state_q != StIdle);
    assign state          = state_q;

endmodule

// File: tb/tb_ib_lut_load_scheduler.sv
// Bench for ib_lut_load_scheduler: request vectors from a table, expected grants
// queued in service order and checked as writes and acknowledges appear.
module tb_ib_lut_load_scheduler;

    logic       write_clk;
    logic       rstn;
    logic [1:0] cnu_wr;
    logic [1:0] vnu_wr;
    logic       dnu_wr;
    logic       iter_termination;
    logic       rom_en;
    logic [8:0] rom_addr;
    logic [1:0] cn_ram_we;
    logic [1:0] vn_ram_we;
    logic       dn_ram_we;
    logic [4:0] ram_waddr;
    logic [1:0] cn_iter_update;
    logic [1:0] vn_iter_update;
    logic       dn_iter_update;
    logic [3:0] iter_cnt;
    logic       max_iter;
    logic       busy;
    logic [2:0] state;

    ib_lut_load_scheduler dut (
        .write_clk        (write_clk),
        .rstn             (rstn),
        .cnu_wr           (cnu_wr),
        .vnu_wr           (vnu_wr),
        .dnu_wr           (dnu_wr),
        .iter_termination (iter_termination),
        .rom_en           (rom_en),
        .rom_addr         (rom_addr),
        .cn_ram_we        (cn_ram_we),
        .vn_ram_we        (vn_ram_we),
        .dn_ram_we        (dn_ram_we),
        .ram_waddr        (ram_waddr),
        .cn_iter_update   (cn_iter_update),
        .vn_iter_update   (vn_iter_update),
        .dn_iter_update   (dn_iter_update),
        .iter_cnt         (iter_cnt),
        .max_iter         (max_iter),
        .busy             (busy),
        .state            (state)
    );

    initial begin
        write_clk = 1'b0;
        forever #5 write_clk = ~write_clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Grant bits: {dn, vn1, vn0, cn1, cn0}
    typedef struct {
        logic [4:0] grant;
        int         words;
    } exp_t;

    typedef struct {
        logic [1:0] cn;
        logic [1:0] vn;
        logic       dn;
        int         n;
        logic [4:0] order [5];
        int         lat;
    } vec_t;

    exp_t       exp_q [$];
    vec_t       vec [6];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         wcount = 0;
    int         first_ack_cyc = 0;
    int         last_ack_cyc = 0;
    int         max_seen = 0;
    bit         gap_chk = 0;
    logic [3:0] model_iter = '0;
    logic [4:0] clr_a = '0;
    logic [4:0] clr_b = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int page_words(input logic [4:0] g);
        return (g[1:0] != 2'b00) ? 32 : 16;
    endfunction

    task automatic push_grant(input logic [4:0] g);
        exp_t e;
        e.grant = g;
        e.words = page_words(g);
        exp_q.push_back(e);
    endtask

    task automatic set_vec(input int idx, input logic [1:0] cn, input logic [1:0] vn,
                           input logic dn, input int n, input logic [4:0] o0,
                           input logic [4:0] o1, input logic [4:0] o2, input logic [4:0] o3,
                           input int lat);
        vec[idx].cn       = cn;
        vec[idx].vn       = vn;
        vec[idx].dn       = dn;
        vec[idx].n        = n;
        vec[idx].order[0] = o0;
        vec[idx].order[1] = o1;
        vec[idx].order[2] = o2;
        vec[idx].order[3] = o3;
        vec[idx].order[4] = 5'h00;
        vec[idx].lat      = lat;
    endtask

    // Compare one sampled cycle of DUT outputs against the scoreboard.
    task automatic monitor();
        logic [4:0] we_v;
        logic [4:0] ack_v;
        exp_t       e;
        we_v  = {dn_ram_we, vn_ram_we, cn_ram_we};
        ack_v = {dn_iter_update, vn_iter_update, cn_iter_update};
        chk("iter_cnt", 32'(iter_cnt), 32'(model_iter));
        if (state == 3'b001) begin
            chk("fetch_rom", 32'({rom_en, rom_addr}), 32'({1'b1, model_iter, 5'd0}));
            if (gap_chk && last_ack_cyc != 0) chk("idle_gap", cyc - last_ack_cyc, 2);
        end
        if (we_v != 5'd0) begin
            if (exp_q.size() == 0) begin
                chk("we_unexpected", 32'(we_v), 32'd0);
            end else begin
                chk("we_grant", 32'(we_v), 32'(exp_q[0].grant));
                chk("ram_waddr", 32'(ram_waddr), wcount);
                chk("load_state", 32'({busy, state}), 32'(4'b1010));
                if (wcount == exp_q[0].words - 1) begin
                    chk("rom_last", 32'(rom_en), 32'd0);
                end else begin
                    chk("rom_next", 32'({rom_en, rom_addr}),
                        32'({1'b1, model_iter, 5'(wcount + 1)}));
                end
                wcount++;
            end
        end
        if (ack_v != 5'd0) begin
            if (exp_q.size() == 0) begin
                chk("ack_unexpected", 32'(ack_v), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("ack", 32'(ack_v), 32'(e.grant));
                chk("words", wcount, e.words);
                chk("max_iter", 32'(max_iter), 32'(e.grant[4] && (model_iter == 4'd9)));
                if (e.grant[4]) model_iter = (model_iter == 4'd9) ? 4'd0 : model_iter + 4'd1;
                if (first_ack_cyc == 0) first_ack_cyc = cyc;
                last_ack_cyc = cyc;
                clr_a = ack_v;
            end
            wcount = 0;
        end else if (max_iter !== 1'b0) begin
            chk("max_iter_stray", 32'(max_iter), 32'd0);
        end
        if (max_iter === 1'b1) max_seen++;
    endtask

    // Requesters drop their request two sampling points after the acknowledge,
    // i.e. still high at the edge ending the first IDLE cycle.
    task automatic run_cycle();
        @(negedge write_clk);
        cyc++;
        if (clr_b != 5'd0) begin
            cnu_wr = cnu_wr & ~clr_b[1:0];
            vnu_wr = vnu_wr & ~clr_b[3:2];
            dnu_wr = dnu_wr & ~clr_b[4];
        end
        clr_b = clr_a;
        clr_a = '0;
        monitor();
    endtask

    task automatic run_until_empty(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            run_cycle();
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("timeout_pending", exp_q.size(), 0);
            exp_q.delete();
        end
        repeat (4) run_cycle();
    endtask

    initial begin
        int n;
        rstn             = 1'b0;
        cnu_wr           = '0;
        vnu_wr           = '0;
        dnu_wr           = 1'b0;
        iter_termination = 1'b0;

        set_vec(0, 2'b01, 2'b00, 1'b0, 1, 5'h01, 5'h00, 5'h00, 5'h00, 34);
        set_vec(1, 2'b11, 2'b01, 1'b1, 4, 5'h01, 5'h02, 5'h04, 5'h10, 34);
        set_vec(2, 2'b00, 2'b10, 1'b0, 1, 5'h08, 5'h00, 5'h00, 5'h00, 18);
        set_vec(3, 2'b10, 2'b11, 1'b0, 3, 5'h02, 5'h04, 5'h08, 5'h00, 34);
        set_vec(4, 2'b00, 2'b00, 1'b1, 1, 5'h10, 5'h00, 5'h00, 5'h00, 18);
        set_vec(5, 2'b01, 2'b10, 1'b1, 3, 5'h01, 5'h08, 5'h10, 5'h00, 34);

        // Reset state
        repeat (2) run_cycle();
        chk("rst_outs_a", 32'({rom_en, rom_addr, cn_ram_we, vn_ram_we, dn_ram_we, ram_waddr}),
            32'd0);
        chk("rst_outs_b", 32'({cn_iter_update, vn_iter_update, dn_iter_update, iter_cnt,
                               max_iter, busy, state}), 32'd0);
        rstn = 1'b1;
        repeat (2) run_cycle();

        // Table-driven request patterns
        for (int v = 0; v < 6; v++) begin
            cnu_wr = vec[v].cn;
            vnu_wr = vec[v].vn;
            dnu_wr = vec[v].dn;
            for (int g = 0; g < vec[v].n; g++) push_grant(vec[v].order[g]);
            first_ack_cyc = 0;
            last_ack_cyc  = 0;
            gap_chk       = 1'b1;
            n = cyc;
            run_until_empty(400);
            chk("first_ack_latency", first_ack_cyc - n, vec[v].lat);
        end

        // Termination at word 7 of iteration 3
        gap_chk = 1'b0;
        chk("term_pre_iter", 32'(iter_cnt), 32'd3);
        push_grant(5'h01);
        cnu_wr = 2'b01;
        n = 0;
        while (wcount < 8 && n < 80) begin
            run_cycle();
            n++;
        end
        chk("term_reach_word7", wcount, 8);
        iter_termination = 1'b1;
        exp_q.delete();
        wcount     = 0;
        model_iter = '0;
        run_cycle();
        chk("term_next_idle", 32'({busy, state}), 32'd0);
        repeat (4) begin
            run_cycle();
            chk("term_hold_idle", 32'({busy, state, cn_iter_update}), 32'd0);
        end
        iter_termination = 1'b0;
        push_grant(5'h01);
        run_until_empty(200);

        // Ten full rounds: iter_cnt walks 0..9 and wraps with max_iter
        gap_chk = 1'b1;
        for (int r = 0; r < 10; r++) begin
            cnu_wr = 2'b11;
            vnu_wr = 2'b11;
            dnu_wr = 1'b1;
            push_grant(5'h01);
            push_grant(5'h02);
            push_grant(5'h04);
            push_grant(5'h08);
            push_grant(5'h10);
            last_ack_cyc = 0;
            run_until_empty(400);
        end
        chk("max_iter_pulses", max_seen, 1);
        chk("iter_after_wrap", 32'(iter_cnt), 32'd0);

        // One DN load so the reset below has a nonzero iter_cnt to clear
        gap_chk = 1'b0;
        dnu_wr  = 1'b1;
        push_grant(5'h10);
        run_until_empty(100);
        chk("iter_before_rst", 32'(iter_cnt), 32'd1);

        // Asynchronous reset in the middle of a VN load
        vnu_wr = 2'b01;
        push_grant(5'h04);
        n = 0;
        while (wcount < 6 && n < 40) begin
            run_cycle();
            n++;
        end
        chk("rst_reach_word5", wcount, 6);
        #2 rstn = 1'b0;
        #1;
        chk("async_rst_a", 32'({rom_en, rom_addr, cn_ram_we, vn_ram_we, dn_ram_we, ram_waddr}),
            32'd0);
        chk("async_rst_b", 32'({cn_iter_update, vn_iter_update, dn_iter_update, iter_cnt,
                                max_iter, busy, state}), 32'd0);
        exp_q.delete();
        wcount     = 0;
        model_iter = '0;
        repeat (2) run_cycle();
        rstn = 1'b1;
        push_grant(5'h04);
        run_until_empty(100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
